// File: rtl/bcd_countdown_timer_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd_countdown_pkg
// Purpose  : Shared types, constants and helpers for the BCD countdown timer.
//            Holds the FSM state encoding, the BCD digit type, the digit
//            constants and the digit clamp function.
// Ports    : none (package)
// Options  : TIMER_PENALTY_EN (used by the interface and top, not here)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Non-decimal nibbles (A..F) are forced to 9 so the datapath only ever
  // holds legal BCD.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_countdown_timer_if.sv
//------------------------------------------------------------------------------
// Module   : bcd_countdown_timer_if
// Purpose  : Control/status bundle of the BCD countdown timer.
// Ports    : load_val, start, stop, pause, sec_tick, [strike] -> timer
//            value, running, expired, done               <- timer
//            master modport = controller side, slave modport = timer side.
// Options  : TIMER_PENALTY_EN adds the strike signal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_countdown_timer_if #(
  parameter int NUM_DIGITS = 3
);

  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    start;
  logic                    stop;
  logic                    pause;
  logic                    sec_tick;
`ifdef TIMER_PENALTY_EN
  logic                    strike;
`endif
  logic [4*NUM_DIGITS-1:0] value;
  logic                    running;
  logic                    expired;
  logic                    done;

`ifdef TIMER_PENALTY_EN
  modport master (
    output load_val, start, stop, pause, sec_tick, strike,
    input  value, running, expired, done
  );
  modport slave (
    input  load_val, start, stop, pause, sec_tick, strike,
    output value, running, expired, done
  );
`else
  modport master (
    output load_val, start, stop, pause, sec_tick,
    input  value, running, expired, done
  );
  modport slave (
    input  load_val, start, stop, pause, sec_tick,
    output value, running, expired, done
  );
`endif

endinterface

`default_nettype wire

// File: rtl/bcd_countdown_timer_sub_digit.sv
//------------------------------------------------------------------------------
// Module   : bcd_sub_digit
// Purpose  : One BCD digit of a ripple subtractor: o_diff = i_a - i_b - i_borrow
//            with decimal correction.
// Ports    : i_a      minuend digit (0..9)
//            i_b      subtrahend digit (0..9)
//            i_borrow borrow from the lower digit
//            o_diff   result digit (0..9)
//            o_borrow borrow to the upper digit
// Options  : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_sub_digit
  import bcd_countdown_pkg::*;
(
  input  bcd_digit_t i_a,
  input  bcd_digit_t i_b,
  input  logic       i_borrow,
  output bcd_digit_t o_diff,
  output logic       o_borrow
);

  logic [4:0] w_raw;

  // Range of the raw difference is -10..9; bit 4 is the sign.
  assign w_raw    = {1'b0, i_a} - {1'b0, i_b} - {4'b0000, i_borrow};
  assign o_borrow = w_raw[4];
  // Negative result: adding 10 modulo 16 to the low nibble yields the digit.
  assign o_diff   = w_raw[4] ? (w_raw[3:0] + 4'd10) : w_raw[3:0];

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
//------------------------------------------------------------------------------
// Module   : bcd_countdown_timer
// Purpose  : Multi-digit BCD countdown timer with pause, stop and optional
//            strike penalty. Counts down one per sec_tick and flags expiry.
// Ports    : clk    clock, rising edge
//            reset  synchronous, active-low
//            bus    bcd_countdown_timer_if.slave (load_val, start, stop, pause,
//                   sec_tick, [strike] in; value, running, expired, done out)
// Options  : TIMER_PENALTY_EN - strike subtracts PENALTY_BCD (plus 1 when a
//            tick coincides), saturating at zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_countdown_timer
  import bcd_countdown_pkg::*;
#(
  parameter int                      NUM_DIGITS  = 3,
  parameter logic [4*NUM_DIGITS-1:0] PENALTY_BCD = 'h010
) (
  input  wire                          clk,
  input  wire                          reset,
  bcd_countdown_timer_if.slave         bus
);

  localparam int W = 4 * NUM_DIGITS;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_value;
  logic [W-1:0]   w_value_nxt;
  logic           r_expired;
  logic           w_expired_nxt;

  logic [W-1:0]   w_load;        // clamped load value
  logic [W-1:0]   w_sub;         // subtrahend fed to the digit chain
  logic [W-1:0]   w_diff;        // chain result
  logic [NUM_DIGITS:0] w_borrow;
  logic           w_event;       // something in RUN wants to subtract
  logic           w_hit_zero;    // subtraction reaches or passes zero

  // Load clamp and subtractor chain, one slice per digit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_load[4*gi +: 4] = bcd_clamp(bus.load_val[4*gi +: 4]);

      bcd_sub_digit u_sub (
        .i_a      (r_value[4*gi +: 4]),
        .i_b      (w_sub[4*gi +: 4]),
        .i_borrow (w_borrow[gi]),
        .o_diff   (w_diff[4*gi +: 4]),
        .o_borrow (w_borrow[gi+1])
      );
    end
  endgenerate

`ifdef TIMER_PENALTY_EN
  // Strike puts the penalty on the subtrahend, the tick rides in as the
  // initial borrow, so strike+tick subtracts PENALTY_BCD + 1 in one pass.
  assign w_sub       = bus.strike ? PENALTY_BCD : {W{1'b0}};
  assign w_borrow[0] = bus.sec_tick;
  assign w_event     = bus.sec_tick | bus.strike;
`else
  // No strike: the chain only ever subtracts 1; PENALTY_BCD is masked off.
  assign w_sub       = PENALTY_BCD & {W{1'b0}};
  assign w_borrow[0] = 1'b1;
  assign w_event     = bus.sec_tick;
`endif

  // A final borrow means the result went negative; saturate to zero.
  assign w_hit_zero = w_borrow[NUM_DIGITS] || (w_diff == {W{1'b0}});

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_value   <= {W{1'b0}};
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_value   <= w_value_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_value_nxt   = r_value;
    w_expired_nxt = 1'b0;

    case (r_state)
      ST_IDLE, ST_EXPIRED: begin
        w_value_nxt = {W{1'b0}};
        if (bus.start) begin
          if (w_load == {W{1'b0}}) begin
            w_state_nxt   = ST_EXPIRED;
            w_expired_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_value_nxt = w_load;
          end
        end else if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_value_nxt = {W{1'b0}};
        end else if (bus.pause) begin
          w_state_nxt = ST_PAUSED;
        end else if (w_event) begin
          if (w_hit_zero) begin
            w_state_nxt   = ST_EXPIRED;
            w_value_nxt   = {W{1'b0}};
            w_expired_nxt = 1'b1;
          end else begin
            w_value_nxt = w_diff;
          end
        end
      end

      ST_PAUSED: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_value_nxt = {W{1'b0}};
        end else if (!bus.pause) begin
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_value_nxt = {W{1'b0}};
      end
    endcase
  end

  assign bus.value   = r_value;
  assign bus.running = (r_state == ST_RUN);
  assign bus.expired = r_expired;
  assign bus.done    = (r_state == ST_EXPIRED);

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_countdown_timer
// Purpose  : Self-checking bench for bcd_countdown_timer (NUM_DIGITS = 3).
//            Each step record carries the inputs and the outputs expected one
//            edge later; the expectation is queued when the step is driven and
//            popped and compared after the edge.
// Ports    : none
// Options  : TIMER_PENALTY_EN enables the strike sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_countdown_timer;

  localparam int ND = 3;
  localparam int W  = 4 * ND;

  typedef struct {
    string        nm;
    logic         rn;
    logic [W-1:0] ld;
    logic         st;
    logic         sp;
    logic         pa;
    logic         tk;
    logic         sk;
    logic [W-1:0] ev;
    logic         er;
    logic         ex;
    logic         ed;
  } vec_t;

  logic clk;
  logic reset;

  bcd_countdown_timer_if #(.NUM_DIGITS(ND)) bus ();

  bcd_countdown_timer #(
    .NUM_DIGITS  (ND),
    .PENALTY_BCD (12'h010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t v(input string nm, input logic rn, input logic [W-1:0] ld,
                             input logic st, input logic sp, input logic pa,
                             input logic tk, input logic sk, input logic [W-1:0] ev,
                             input logic er, input logic ex, input logic ed);
    vec_t r;
    r.nm = nm; r.rn = rn; r.ld = ld; r.st = st; r.sp = sp; r.pa = pa;
    r.tk = tk; r.sk = sk; r.ev = ev; r.er = er; r.ex = ex; r.ed = ed;
    return r;
  endfunction

  task automatic chk1(input string nm, input string fld, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    reset        = t.rn;
    bus.load_val = t.ld;
    bus.start    = t.st;
    bus.stop     = t.sp;
    bus.pause    = t.pa;
    bus.sec_tick = t.tk;
`ifdef TIMER_PENALTY_EN
    bus.strike   = t.sk;
`endif
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk1(e.nm, "value",   bus.value,            e.ev);
    chk1(e.nm, "running", {{(W-1){1'b0}}, bus.running}, {{(W-1){1'b0}}, e.er});
    chk1(e.nm, "expired", {{(W-1){1'b0}}, bus.expired}, {{(W-1){1'b0}}, e.ex});
    chk1(e.nm, "done",    {{(W-1){1'b0}}, bus.done},    {{(W-1){1'b0}}, e.ed});
  endtask

  // Reset in the middle of a countdown and on the edge that would expire.
  task automatic seq_reset();
    apply(v("r_ld050", 1, 12'h050, 1,0,0,0,0, 12'h050, 1,0,0));
    apply(v("r_t049",  1, 12'h000, 0,0,0,1,0, 12'h049, 1,0,0));
    apply(v("r_t048",  1, 12'h000, 0,0,0,1,0, 12'h048, 1,0,0));
    apply(v("r_t047",  1, 12'h000, 0,0,0,1,0, 12'h047, 1,0,0));
    apply(v("r_mid",   0, 12'h000, 0,0,0,1,0, 12'h000, 0,0,0));
    apply(v("r_after", 1, 12'h000, 0,0,0,0,0, 12'h000, 0,0,0));
    apply(v("r_ld001", 1, 12'h001, 1,0,0,0,0, 12'h001, 1,0,0));
    apply(v("r_noexp", 0, 12'h000, 0,0,0,1,0, 12'h000, 0,0,0));
    apply(v("r_idle",  1, 12'h000, 0,0,0,0,0, 12'h000, 0,0,0));
    apply(v("r_ld001b",1, 12'h001, 1,0,0,0,0, 12'h001, 1,0,0));
    apply(v("r_exp",   1, 12'h000, 0,0,0,1,0, 12'h000, 0,1,1));
    apply(v("r_inpulse",0,12'h000, 0,0,0,0,0, 12'h000, 0,0,0));
  endtask

`ifdef TIMER_PENALTY_EN
  task automatic seq_penalty();
    apply(v("p_ld015", 1, 12'h015, 1,0,0,0,0, 12'h015, 1,0,0));
    apply(v("p_s005",  1, 12'h000, 0,0,0,0,1, 12'h005, 1,0,0));
    apply(v("p_pause", 1, 12'h000, 0,0,1,1,1, 12'h005, 0,0,0));
    apply(v("p_psk",   1, 12'h000, 0,0,1,0,1, 12'h005, 0,0,0));
    apply(v("p_resume",1, 12'h000, 0,0,0,0,0, 12'h005, 1,0,0));
    apply(v("p_sat",   1, 12'h000, 0,0,0,1,1, 12'h000, 0,1,1));
    apply(v("p_ld050", 1, 12'h050, 1,0,0,0,0, 12'h050, 1,0,0));
    apply(v("p_st039", 1, 12'h000, 0,0,0,1,1, 12'h039, 1,0,0));
    apply(v("p_stop",  1, 12'h000, 0,1,0,1,1, 12'h000, 0,0,0));
    apply(v("p_ld100", 1, 12'h100, 1,0,0,0,0, 12'h100, 1,0,0));
    apply(v("p_s090",  1, 12'h000, 0,0,0,0,1, 12'h090, 1,0,0));
    apply(v("p_stop2", 1, 12'h000, 0,1,0,0,0, 12'h000, 0,0,0));
    apply(v("p_ld010", 1, 12'h010, 1,0,0,0,0, 12'h010, 1,0,0));
    apply(v("p_exact", 1, 12'h000, 0,0,0,0,1, 12'h000, 0,1,1));
    apply(v("p_hold",  1, 12'h000, 0,0,0,0,1, 12'h000, 0,0,1));
    apply(v("p_stop3", 1, 12'h000, 0,1,0,0,0, 12'h000, 0,0,0));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.load_val = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.sec_tick = 1'b0;
`ifdef TIMER_PENALTY_EN
    bus.strike   = 1'b0;
`endif

    //            name        rn  load    st sp pa tk sk  value  run exp done
    tbl.push_back(v("rst",       0, 12'h000, 0,0,0,0,0, 12'h000, 0,0,0));
    tbl.push_back(v("rst_start", 0, 12'h123, 1,0,0,0,0, 12'h000, 0,0,0));
    tbl.push_back(v("idle",      1, 12'h000, 0,0,0,0,0, 12'h000, 0,0,0));
    tbl.push_back(v("idle_tick", 1, 12'h000, 0,0,0,1,0, 12'h000, 0,0,0));
    tbl.push_back(v("ld003",     1, 12'h003, 1,0,0,0,0, 12'h003, 1,0,0));
    tbl.push_back(v("t002",      1, 12'h000, 0,0,0,1,0, 12'h002, 1,0,0));
    tbl.push_back(v("hold002",   1, 12'h000, 0,0,0,0,0, 12'h002, 1,0,0));
    tbl.push_back(v("t001",      1, 12'h000, 0,0,0,1,0, 12'h001, 1,0,0));
    tbl.push_back(v("t000",      1, 12'h000, 0,0,0,1,0, 12'h000, 0,1,1));
    tbl.push_back(v("exp_hold",  1, 12'h000, 0,0,0,0,0, 12'h000, 0,0,1));
    tbl.push_back(v("exp_tick",  1, 12'h000, 0,0,0,1,0, 12'h000, 0,0,1));
    tbl.push_back(v("ld100",     1, 12'h100, 1,0,0,0,0, 12'h100, 1,0,0));
    tbl.push_back(v("t099",      1, 12'h000, 0,0,0,1,0, 12'h099, 1,0,0));
    tbl.push_back(v("stop",      1, 12'h000, 0,1,0,0,0, 12'h000, 0,0,0));
    tbl.push_back(v("ld000",     1, 12'h000, 1,0,0,0,0, 12'h000, 0,1,1));
    tbl.push_back(v("exp_hold2", 1, 12'h000, 0,0,0,0,0, 12'h000, 0,0,1));
    tbl.push_back(v("ld020",     1, 12'h020, 1,0,0,0,0, 12'h020, 1,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v("paused",  1, 12'h000, 0,0,1,1,0, 12'h020, 0,0,0));
    tbl.push_back(v("resume",    1, 12'h000, 0,0,0,0,0, 12'h020, 1,0,0));
    tbl.push_back(v("t019",      1, 12'h000, 0,0,0,1,0, 12'h019, 1,0,0));
    tbl.push_back(v("stop2",     1, 12'h000, 0,1,0,0,0, 12'h000, 0,0,0));
    tbl.push_back(v("ld1AF",     1, 12'h1AF, 1,0,0,0,0, 12'h199, 1,0,0));
    tbl.push_back(v("restart",   1, 12'h005, 1,0,0,0,0, 12'h199, 1,0,0));
    tbl.push_back(v("t198",      1, 12'h000, 0,0,0,1,0, 12'h198, 1,0,0));
    tbl.push_back(v("pause2",    1, 12'h000, 0,0,1,0,0, 12'h198, 0,0,0));
    tbl.push_back(v("p_start",   1, 12'h005, 1,0,1,0,0, 12'h198, 0,0,0));
    tbl.push_back(v("p_stop",    1, 12'h000, 0,1,1,0,0, 12'h000, 0,0,0));
    tbl.push_back(v("ldFFF",     1, 12'hFFF, 1,0,0,0,0, 12'h999, 1,0,0));
    tbl.push_back(v("t998",      1, 12'h000, 0,0,0,1,0, 12'h998, 1,0,0));
    tbl.push_back(v("stop_tick", 1, 12'h000, 0,1,1,1,0, 12'h000, 0,0,0));
    tbl.push_back(v("stop_idle", 1, 12'h000, 0,1,0,0,0, 12'h000, 0,0,0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    seq_reset();
`ifdef TIMER_PENALTY_EN
    apply(v("p_pre", 1, 12'h000, 0,0,0,0,0, 12'h000, 0,0,0));
    seq_penalty();
`endif

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard got=%0d expected=0 pending", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
